serial_adder: RTL and testbench



---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/serial_adder_digit.sv | 33 +++
 rtl/serial_adder.sv | 121 ++++++++++++
 tb/tb_serial_adder.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
package serial_adder_pkg;

    // Control state. Completion is signalled by a registered done flag,
    // so it does not need a state of its own.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Width of a counter that must be able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple adder.
// Each bit uses two half adders and an OR gate to merge their carries.
module adder_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] p;
    logic [DIGIT-1:0] g;
    logic [DIGIT-1:0] h;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        // First half adder: operand bits.
        assign p[i]     = a[i] ^ b[i];
        assign g[i]     = a[i] & b[i];
        // Second half adder: partial sum plus incoming carry.
        assign s[i]     = p[i] ^ c[i];
        assign h[i]     = p[i] & c[i];
        // At most one of the two half-adder carries can be set.
        assign c[i + 1] = g[i] | h[i];
    end

    assign co = c[DIGIT];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: {carry,sum} = input1 + input2 + cin.
// The operation processes DIGIT bits per clock, starting with the LSB digit.
// Handshake: start is accepted on an edge where busy=0, and the operands
// are captured on that edge. Busy stays high for N = WIDTH/DIGIT cycles.
// Done then pulses for one cycle, and sum/carry hold until the next
// accepted start.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int            N    = WIDTH / DIGIT;
    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $fatal(1, "serial_adder: DIGIT must be >=1 and divide WIDTH exactly");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cr_q, cr_d;        // carry linking consecutive digits
    logic             carry_q, carry_d;  // visible carry-out, final value only
    logic             done_q, done_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co;

    adder_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (a_q[DIGIT-1:0]),
        .b  (b_q[DIGIT-1:0]),
        .ci (cr_q),
        .s  (dig_s),
        .co (dig_co)
    );

    // Next-state logic: accept in IDLE, then run one digit per cycle in RUN.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cr_d    = cr_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // sum/carry are left alone here so the previous result stays
                // readable through the accept edge.
                if (start) begin
                    a_d     = input1;
                    b_d     = input2;
                    cr_d    = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // The new digit enters at the top of sum. After N shifts the
                // first digit has reached bit 0.
                sum_d = (sum_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
                a_d   = a_q >> DIGIT;
                b_d   = b_q >> DIGIT;
                cr_d  = dig_co;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    carry_d = dig_co;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cr_q    <= 1'b0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cr_q    <= cr_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder. It drives two instances: 8-bit/1-bit digits and
// 16-bit/4-bit digits. A transaction-level model predicts busy, done and the
// held result, and is checked every cycle. Directed cases add literal
// expectations.
module tb_serial_adder;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT wiring ----------------
    logic [1:0]       st;
    logic [1:0]       ci;
    logic [15:0]      ia [2];
    logic [15:0]      ib [2];
    logic [1:0]       bz;
    logic [1:0]       dn;
    logic [1:0]       cy;
    logic [7:0]       sum8;
    logic [15:0]      sum16;
    logic [1:0][15:0] sm;

    assign sm[0] = {8'h00, sum8};
    assign sm[1] = sum16;

    serial_adder #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (st[0]),
        .input1 (ia[0][7:0]),
        .input2 (ib[0][7:0]),
        .cin    (ci[0]),
        .busy   (bz[0]),
        .done   (dn[0]),
        .sum    (sum8),
        .carry  (cy[0])
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (st[1]),
        .input1 (ia[1]),
        .input2 (ib[1]),
        .cin    (ci[1]),
        .busy   (bz[1]),
        .done   (dn[1]),
        .sum    (sum16),
        .carry  (cy[1])
    );

    // ---------------- counters / check ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [16:0] act, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nn(input int k);
        return (k == 0) ? 8 : 4;
    endfunction

    // Returns {carry, 16-bit sum}; for the 8-bit unit the sum sits in [7:0].
    function automatic logic [16:0] ref_add(input int k, input logic [15:0] a,
                                            input logic [15:0] b, input logic c);
        logic [8:0]  t8;
        logic [16:0] t16;
        if (k == 0) begin
            t8 = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'h00, c};
            return {t8[8], 8'h00, t8[7:0]};
        end
        t16 = {1'b0, a} + {1'b0, b} + {16'h0000, c};
        return t16;
    endfunction

    logic [1:0]  m_busy;
    logic [1:0]  m_done;
    int          m_left [2];
    logic [16:0] m_res  [2];   // published {carry,sum}
    logic [16:0] m_pend [2];   // result of the addition in flight

    // Per-transaction model: accept when idle, count N cycles, then publish.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_busy[k] <= 1'b0;
                m_done[k] <= 1'b0;
                m_left[k] <= 0;
                m_res[k]  <= '0;
                m_pend[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] <= m_busy[k] && (m_left[k] == 1);
                if (m_busy[k]) begin
                    m_left[k] <= m_left[k] - 1;
                    if (m_left[k] == 1) begin
                        m_busy[k] <= 1'b0;
                        m_res[k]  <= m_pend[k];
                    end
                end else if (st[k]) begin
                    m_busy[k] <= 1'b1;
                    m_left[k] <= nn(k);
                    m_pend[k] <= ref_add(k, ia[k], ib[k], ci[k]);
                end
            end
        end
    end

    // Compare every cycle. The result is checked while idle, and also in the
    // first busy cycle, where it must still show the previous value.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy%0d", k), 17'(bz[k]), 17'(m_busy[k]));
            chk($sformatf("done%0d", k), 17'(dn[k]), 17'(m_done[k]));
            if (!m_busy[k] || m_left[k] == nn(k)) begin
                chk($sformatf("sum%0d", k), 17'(sm[k]), 17'(m_res[k][15:0]));
                chk($sformatf("carry%0d", k), 17'(cy[k]), 17'(m_res[k][16]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; leaves at the negedge after the accept edge.
    task automatic go(input int k, input logic [15:0] a, input logic [15:0] b, input logic c);
        st[k] = 1'b1;
        ia[k] = a;
        ib[k] = b;
        ci[k] = c;
        @(negedge clk);
        st[k] = 1'b0;
        ia[k] = 16'($urandom);
        ib[k] = 16'($urandom);
        ci[k] = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(input int k, inout int n);
        while (!dn[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!dn[k]) chk($sformatf("done_timeout%0d", k), 17'(dn[k]), 17'(1));
    endtask

    task automatic op(input int k, input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] es, input logic ec, input int en, input string nm);
        int n;
        n = 0;
        go(k, a, b, c);
        wait_done(k, n);
        chk({nm, "_lat"}, 17'(n), 17'(en));
        chk({nm, "_sum"}, 17'(sm[k]), 17'(es));
        chk({nm, "_carry"}, 17'(cy[k]), 17'(ec));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int cnt_d;
        int cnt_b;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic [16:0] r;

        rst_n = 1'b0;
        st    = '0;
        ci    = '0;
        for (int k = 0; k < 2; k++) begin
            ia[k] = '0;
            ib[k] = '0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", 17'(bz[k]), 17'(0));
            chk("rst_done", 17'(dn[k]), 17'(0));
            chk("rst_sum", 17'(sm[k]), 17'(0));
            chk("rst_carry", 17'(cy[k]), 17'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Full carry chain and the carry-in path.
        op(0, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 8, "ff_01");
        @(negedge clk);
        chk("done_width", 17'(dn[0]), 17'(0));
        op(0, 16'h00A5, 16'h005A, 1'b1, 16'h0000, 1'b1, 8, "a5_5a_c");
        repeat (2) @(negedge clk);
        op(0, 16'h0012, 16'h0034, 1'b0, 16'h0046, 1'b0, 8, "12_34");
        repeat (2) @(negedge clk);

        // A start pulse sampled at t0+3 must be ignored.
        n = 0;
        go(0, 16'h0033, 16'h0044, 1'b1);
        repeat (2) begin
            @(negedge clk);
            n++;
        end
        st[0] = 1'b1;
        ia[0] = 16'h0001;
        ib[0] = 16'h0001;
        ci[0] = 1'b0;
        @(negedge clk);
        n++;
        st[0] = 1'b0;
        wait_done(0, n);
        chk("ign_lat", 17'(n), 17'(8));
        chk("ign_sum", 17'(sm[0]), 17'(16'h0078));
        chk("ign_carry", 17'(cy[0]), 17'(0));
        cnt_d = 0;
        cnt_b = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn[0]) cnt_d++;
            if (bz[0]) cnt_b++;
        end
        chk("ign_extra_done", 17'(cnt_d), 17'(0));
        chk("ign_extra_busy", 17'(cnt_b), 17'(0));

        // Back-to-back: the second start is issued in the done cycle.
        op(0, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 8, "b2b_first");
        n = 0;
        go(0, 16'h007F, 16'h0001, 1'b1);
        chk("b2b_hold_sum", 17'(sm[0]), 17'(16'h0000));
        chk("b2b_hold_carry", 17'(cy[0]), 17'(1));
        wait_done(0, n);
        chk("b2b_lat", 17'(n), 17'(8));
        chk("b2b_sum", 17'(sm[0]), 17'(16'h0081));
        chk("b2b_carry", 17'(cy[0]), 17'(0));
        repeat (3) @(negedge clk);

        // Reset at t0+4 aborts the operation immediately.
        go(0, 16'h00FF, 16'h0001, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 17'(bz[0]), 17'(0));
        chk("abort_done", 17'(dn[0]), 17'(0));
        chk("abort_sum", 17'(sm[0]), 17'(0));
        chk("abort_carry", 17'(cy[0]), 17'(0));
        @(negedge clk);
        rst_n = 1'b1;
        cnt_d = 0;
        repeat (12) begin
            @(negedge clk);
            if (dn[0] || bz[0]) cnt_d++;
        end
        chk("abort_quiet", 17'(cnt_d), 17'(0));

        // Wide digits.
        op(1, 16'h1234, 16'hFEDC, 1'b0, 16'h1110, 1'b1, 4, "wide");
        repeat (2) @(negedge clk);
        op(1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4, "wide_cin");
        repeat (2) @(negedge clk);

        // Random operand pairs, issued back-to-back.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            r  = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            op(1, ra, rb, rc, r[15:0], r[16], 4, "rnd16");
        end
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            r  = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
            op(0, ra, rb, rc, {8'h00, r[7:0]}, r[8], 8, "rnd8");
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
